uart_tx_param: RTL



---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_sync_fifo.sv | 90 +++++++++
 rtl/uart_tx_param.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the parametrised UART transmitter.
//   uart_state_e : transmitter FSM states
//   PAR_*        : values accepted by the PARITY parameter
//   frame_cycles : length of one frame in clock cycles for a given format
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Start bit + data bits + optional parity bit + stop bits, each one bit period long.
    function automatic int unsigned frame_cycles(input int unsigned clk_div,
                                                 input int unsigned data_bits,
                                                 input int unsigned parity,
                                                 input int unsigned stop_bits);
        int unsigned n_bits;
        n_bits = 1 + data_bits + stop_bits;
        if (parity != PAR_NONE) begin
            n_bits = n_bits + 1;
        end
        return n_bits * clk_div;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Small synchronous FIFO buffering bytes ahead of the UART serialiser.
// Ports:
//   clk_48    in   clock
//   rst       in   synchronous active-high reset, empties the FIFO
//   push      in   write push_data (ignored while full)
//   push_data in   WIDTH-bit entry to store
//   pop       in   drop the head entry (ignored while level is zero)
//   pop_data  out  head entry, valid while not empty
//   full      out  level == DEPTH, decoded from the level register only
//   empty     out  registered empty flag
//   level     out  number of entries held
// DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_48,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   level_q;
    logic [PTR_W:0]   level_d;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (level_q == LEVEL_FULL);
    assign empty    = empty_q;
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];

    assign do_push = push && !full;
    assign do_pop  = pop && (level_q != '0);

    always_comb begin
        level_d = level_q;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Storage carries no reset; only pointers and level define what is valid.
    always_ff @(posedge clk_48) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // The empty flag trails the level by one cycle, so a freshly written entry is
    // offered to the reader on the cycle after its write edge. The stale
    // "non-empty" cycle after a final pop is harmless: pops are gated on level_q.
    always_ff @(posedge clk_48) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
            empty_q <= (level_q == '0);
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// ---------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART transmitter: buffers bytes from a valid/ready stream in a
// small FIFO and serialises them LSB first as start/data/[parity]/stop frames.
// Ports:
//   clk_48     in   sole clock
//   rst        in   synchronous active-high reset; aborts any frame in flight
//   in_data    in   DATA_BITS-wide word to send
//   in_valid   in   in_data valid
//   in_ready   out  FIFO can accept (registered, no path from in_valid)
//   tx         out  serial line, idle high
//   dtr        in   host DTR
//   dsr, cd    out  loop back dtr
//   rts        in   host RTS; high permits a new frame to start
//   cts        out  loops back rts
//   busy       out  a frame is in progress
//   frame_done out  high on the last cycle of the last stop bit
//   fifo_level out  entries waiting in the FIFO
// ---------------------------------------------------------------------------
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 10,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_48,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    input  logic                          dtr,
    output logic                          dsr,
    output logic                          cd,
    input  logic                          rts,
    output logic                          cts,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    // Bit index covers up to 8 data bits and up to 2 stop bits.
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam bit               HAS_PAR   = (PARITY != PAR_NONE);
    localparam bit               ODD_PAR   = (PARITY == PAR_ODD);

    uart_state_e          state_q;
    uart_state_e          state_d;
    logic [DIV_W-1:0]     cnt_q;
    logic [DIV_W-1:0]     cnt_d;
    logic [2:0]           bit_q;
    logic [2:0]           bit_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic                 par_q;
    logic                 par_d;
    logic                 tx_q;
    logic                 tx_d;

    logic                 bit_end;
    logic                 start_ok;
    logic                 start_frame;
    logic                 fifo_pop;
    logic                 fifo_push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 head_par;

    // ------------------------------------------------------------------
    // Input buffer
    // ------------------------------------------------------------------
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk_48    (clk_48),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Parity is fixed when the word is loaded so the shifter can consume bits freely.
    assign head_par = ODD_PAR ? ~^fifo_head : ^fifo_head;

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    assign bit_end  = (cnt_q == DIV_LAST);
    // rts is only consulted here, i.e. at frame boundaries.
    assign start_ok = !fifo_empty && rts;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tx_d        = tx_q;
        start_frame = 1'b0;
        frame_done  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (start_ok) begin
                    start_frame = 1'b1;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (HAS_PAR) begin
                            state_d = PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end

            PAR: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end

            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == STOP_LAST) begin
                        frame_done = 1'b1;
                        bit_d      = '0;
                        if (start_ok) begin
                            // Chain straight into the next start bit, no idle gap.
                            start_frame = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase

        if (start_frame) begin
            state_d = START;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = fifo_head;
            par_d   = head_par;
            tx_d    = 1'b0;
        end
    end

    assign fifo_pop = start_frame;

    always_ff @(posedge clk_48) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs and modem-line loopback
    // ------------------------------------------------------------------
    assign tx   = tx_q;
    assign busy = (state_q != IDLE);
    assign dsr  = dtr;
    assign cd   = dtr;
    assign cts  = rts;

endmodule
